// File: rtl/demux4_route_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux4_route_pkg
//  Description : Shared constants, select encodings and helpers for the
//                registered 1-to-4 valid/ready demultiplexer.
//  Revision    : 1.0  initial release
// ============================================================================
package demux4_route_pkg;

  // Number of destination channels and width of the select that picks one.
  localparam int NUM_CH    = 4;
  localparam int SEL_W     = 2;

  // Default data width of the producer stream and every channel.
  localparam int DEF_WIDTH = 32;

  // Width of the accepted-transfer counter (wraps naturally).
  localparam int CNT_W     = 8;

  // Destination select encodings.
  typedef enum logic [SEL_W-1:0] {
    CH0 = 2'b00,
    CH1 = 2'b01,
    CH2 = 2'b10,
    CH3 = 2'b11
  } ch_sel_e;

  // Turn a binary destination select into a one-hot channel mask.
  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] mask;
    mask      = '0;
    mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage : demux4_route_pkg
`default_nettype wire

// File: rtl/demux4_route_slot.sv
`default_nettype none
// ============================================================================
//  Module      : demux_slot
//  Description : Single-entry holding register for one demux destination.
//                A valid bit plus a data register with a valid/ready output
//                handshake; reports whether it can take a new word this cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module demux_slot
  import demux4_route_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             take,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic             slot_ready
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // The slot can take a word when empty, or when the consumer drains it in
  // the same cycle (which keeps a single always-ready channel at full rate).
  assign slot_ready = !r_valid || take;

  // Hold/refill/drain the entry. A load wins over a drain so a simultaneous
  // drain-and-load keeps the slot valid with the new word. The data register
  // only moves on load, so it is stable while stalled and while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= din;
    end else if (take) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign dout  = r_data;

endmodule : demux_slot
`default_nettype wire

// File: rtl/demux4_route.sv
`default_nettype none
// ============================================================================
//  Module      : demux4_route
//  Description : Registered 1-to-4 demultiplexer with per-destination
//                valid/ready handshakes. One producer stream is steered by
//                's' into one of four single-entry holding slots, so a slow
//                consumer stalls only the transfers addressed to it.
//  Revision    : 1.0  initial release
// ============================================================================
module demux4_route
  import demux4_route_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  s,
  input  logic [WIDTH-1:0]  d,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [WIDTH-1:0]  y0,
  output logic [WIDTH-1:0]  y1,
  output logic [WIDTH-1:0]  y2,
  output logic [WIDTH-1:0]  y3,
  output logic [CNT_W-1:0]  xfer_cnt
);

  logic [NUM_CH-1:0] w_sel_onehot;
  logic [NUM_CH-1:0] w_load;
  logic [NUM_CH-1:0] w_slot_ready;
  logic [NUM_CH-1:0] w_valid;
  logic [WIDTH-1:0]  w_dout [NUM_CH];
  logic              w_accept;
  logic [CNT_W-1:0]  r_xfer_cnt;

  // Readiness follows the addressed slot only; it never looks at in_valid,
  // so the producer may use it to decide whether to present a transfer.
  assign in_ready     = w_slot_ready[s];
  assign w_accept     = in_valid && in_ready;

  // One-hot load strobe: only the addressed slot sees an accept.
  assign w_sel_onehot = sel_onehot(s);
  assign w_load       = w_accept ? w_sel_onehot : '0;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (w_load[i]),
      .din        (d),
      .take       (out_ready[i]),
      .valid      (w_valid[i]),
      .dout       (w_dout[i]),
      .slot_ready (w_slot_ready[i])
    );
  end

  // Count every accepted transfer; the counter wraps modulo 2**CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_cnt <= '0;
    end else if (w_accept) begin
      r_xfer_cnt <= r_xfer_cnt + 1'b1;
    end
  end

  assign out_valid = w_valid;
  assign y0        = w_dout[0];
  assign y1        = w_dout[1];
  assign y2        = w_dout[2];
  assign y3        = w_dout[3];
  assign xfer_cnt  = r_xfer_cnt;

endmodule : demux4_route
`default_nettype wire

// File: tb/tb_demux4_route.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux4_route
//  Description : Directed self-checking bench for demux4_route.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_demux4_route;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       s;
  logic [WIDTH-1:0] d;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] y0, y1, y2, y3;
  logic [7:0]       xfer_cnt;

  int checks;
  int errors;

  demux4_route #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    s         = 2'b10;
    d         = 32'hDEAD_BEEF;
    out_ready = 4'b0000;

    // Reset held two cycles while a transfer is offered: nothing may load.
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_valid", out_valid, 4'b0000);
      chk("rst_y0", y0, 0);
      chk("rst_y1", y1, 0);
      chk("rst_y2", y2, 0);
      chk("rst_y3", y3, 0);
      chk("rst_cnt", xfer_cnt, 0);
    end

    // Release: ch2 loads one edge later.
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);
    tick();
    chk("first_valid", out_valid, 4'b0100);
    chk("first_y2", y2, 32'hDEAD_BEEF);
    chk("first_cnt", xfer_cnt, 1);

    // Drain ch2 so all channels are empty.
    in_valid  = 1'b0;
    out_ready = 4'b0100;
    tick();
    chk("drain2_valid", out_valid, 4'b0000);
    chk("drain2_y2_hold", y2, 32'hDEAD_BEEF);
    out_ready = 4'b0000;

    // Routing: four consecutive accepts to ch0..ch3.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      d = 32'(17 * (i + 1));
      #1;
      chk("route_ready", in_ready, 1);
      tick();
      chk("route_cnt", xfer_cnt, 2 + i);
    end
    chk("route_valid", out_valid, 4'b1111);
    chk("route_y0", y0, 32'h11);
    chk("route_y1", y1, 32'h22);
    chk("route_y2", y2, 32'h33);
    chk("route_y3", y3, 32'h44);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      #1;
      chk("full_ready", in_ready, 0);
    end

    // Empty ch3 only.
    out_ready = 4'b1000;
    tick();
    chk("drain3_valid", out_valid, 4'b0111);
    out_ready = 4'b0000;

    // Stall isolation: ch1 full and stalled, ch3 empty.
    in_valid = 1'b1;
    s        = 2'b01;
    d        = 32'h55;
    #1;
    chk("stall_ready", in_ready, 0);
    tick();
    chk("stall_y1", y1, 32'h22);
    chk("stall_valid", out_valid, 4'b0111);
    chk("stall_cnt", xfer_cnt, 5);
    s = 2'b11;
    #1;
    chk("iso_ready", in_ready, 1);
    tick();
    chk("iso_y3", y3, 32'h55);
    chk("iso_y1", y1, 32'h22);
    chk("iso_valid", out_valid, 4'b1111);
    chk("iso_cnt", xfer_cnt, 6);

    // Simultaneous drain and load on ch0.
    out_ready = 4'b0001;
    s         = 2'b00;
    d         = 32'hA;
    #1;
    chk("dl_ready_a", in_ready, 1);
    tick();
    chk("dl_y0_a", y0, 32'hA);
    chk("dl_valid_a", out_valid, 4'b1111);
    d = 32'hB;
    #1;
    chk("dl_ready_b", in_ready, 1);
    tick();
    chk("dl_y0_b", y0, 32'hB);
    chk("dl_valid_b", out_valid[0], 1);
    chk("dl_cnt", xfer_cnt, 8);

    // 100 back-to-back transfers into ch0 with no bubble.
    for (int k = 0; k < 100; k++) begin
      d = 32'h1000 + 32'(k);
      #1;
      chk("b2b_ready", in_ready, 1);
      tick();
      chk("b2b_y0", y0, 32'h1000 + 32'(k));
    end
    chk("b2b_cnt", xfer_cnt, 108);
    chk("b2b_valid", out_valid, 4'b1111);

    // All four consumers drain together; data holds while empty.
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    tick();
    chk("drain_all", out_valid, 4'b0000);
    chk("empty_y1_hold", y1, 32'h22);
    chk("empty_y3_hold", y3, 32'h55);

    // Fresh reset, then 257 accepts for the counter wrap.
    rst = 1'b1;
    tick();
    chk("rst2_cnt", xfer_cnt, 0);
    chk("rst2_y1", y1, 0);
    rst       = 1'b0;
    in_valid  = 1'b1;
    s         = 2'b00;
    out_ready = 4'b0001;
    for (int k = 0; k < 257; k++) begin
      d = 32'(k);
      tick();
      if (k == 254) chk("wrap_255", xfer_cnt, 255);
      if (k == 255) chk("wrap_0", xfer_cnt, 0);
    end
    chk("wrap_1", xfer_cnt, 1);
    chk("wrap_y0", y0, 256);

    // Reset mid-stall on ch2.
    in_valid  = 1'b1;
    out_ready = 4'b0000;
    s         = 2'b10;
    d         = 32'h77;
    tick();
    chk("ms_load_valid", out_valid[2], 1);
    chk("ms_load_y2", y2, 32'h77);
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    chk("ms_rst_valid", out_valid, 4'b0000);
    chk("ms_rst_y2", y2, 0);
    chk("ms_rst_cnt", xfer_cnt, 0);
    rst       = 1'b0;
    out_ready = 4'b0100;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("ms_no_hs_valid", out_valid[2], 0);
      chk("ms_no_hs_y2", y2, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_demux4_route
`default_nettype wire
